// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared enums and constants for the memory transaction checker
package bp_me_pkg;

    typedef enum logic [2:0] {
        e_none      = 3'd0,
        e_underflow = 3'd1,
        e_mismatch  = 3'd2,
        e_overflow  = 3'd3,
        e_timeout   = 3'd4
    } bp_mem_txn_err_e;

    typedef enum logic [1:0] {
        e_idle,
        e_busy,
        e_error
    } bp_mem_txn_state_e;

    localparam int mem_type_width_lp = 4;

endpackage

// File: rtl/bp_nonsynth_txn_fifo.sv
// bp_nonsynth_txn_fifo: in-order record of outstanding command headers
module bp_nonsynth_txn_fifo #(
    parameter int width_p = 44,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               deq_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int pw_lp = $clog2(els_p);
    localparam int cw_lp = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [pw_lp-1:0]   wptr, rptr;
    logic [cw_lp-1:0]   cnt;

    // storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk_i)
        if (enq_i) mem[wptr] <= data_i;

    // pointers wrap naturally; count distinguishes full from empty
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wptr + pw_lp'(enq_i);
            rptr <= rptr + pw_lp'(deq_i);
            cnt  <= cnt + cw_lp'(enq_i) - cw_lp'(deq_i);
        end

    assign data_o  = mem[rptr];
    assign full_o  = cnt == cw_lp'(els_p);
    assign empty_o = cnt == '0;

endmodule

// File: rtl/bp_nonsynth_mem_txn_checker.sv
// bp_nonsynth_mem_txn_checker: passive in-order checker for the CCE-to-memory link
module bp_nonsynth_mem_txn_checker
    import bp_me_pkg::*;
#(
    parameter int paddr_width_p     = 40,
    parameter int max_outstanding_p = 8,
    parameter int timeout_p         = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   cmd_v_i,
    input  logic                                   cmd_ready_and_i,
    input  logic                                   cmd_last_i,
    input  logic [mem_type_width_lp-1:0]           cmd_msg_type_i,
    input  logic [paddr_width_p-1:0]               cmd_addr_i,
    input  logic                                   resp_v_i,
    input  logic                                   resp_ready_and_i,
    input  logic                                   resp_last_i,
    input  logic [mem_type_width_lp-1:0]           resp_msg_type_i,
    input  logic [paddr_width_p-1:0]               resp_addr_i,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                   error_o,
    output logic [2:0]                             error_code_o
);

    localparam int hw_lp = mem_type_width_lp + paddr_width_p;
    localparam int cw_lp = $clog2(max_outstanding_p + 1);
    localparam int tw_lp = $clog2(timeout_p + 1);

    bp_mem_txn_state_e state;
    bp_mem_txn_err_e   err;
    logic              cmd_first, resp_first, cmd_fire, resp_fire, cmd_hdr, resp_hdr;
    logic              full, empty, live, enq, deq;
    logic [hw_lp-1:0]  head;
    logic [cw_lp-1:0]  cnt_n;
    logic [tw_lp-1:0]  timer;

    // classify this cycle's handshakes and pick the highest-priority error
    always_comb begin
        cmd_fire  = cmd_v_i & cmd_ready_and_i;
        resp_fire = resp_v_i & resp_ready_and_i;
        cmd_hdr   = cmd_fire & cmd_first;
        resp_hdr  = resp_fire & resp_first;
        err = (state == e_error)                                    ? e_none
            : (resp_hdr & empty)                                    ? e_underflow
            : (resp_hdr & (head != {resp_msg_type_i, resp_addr_i})) ? e_mismatch
            : (cmd_hdr & full)                                      ? e_overflow
            : (state == e_busy && timer == tw_lp'(timeout_p))       ? e_timeout
            : e_none;
        live  = (state != e_error) & (err == e_none);
        enq   = live & cmd_hdr;
        deq   = live & resp_hdr;
        cnt_n = outstanding_o + cw_lp'(enq) - cw_lp'(deq);
    end

    bp_nonsynth_txn_fifo #(
        .width_p(hw_lp),
        .els_p  (max_outstanding_p)
    ) fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .enq_i    (enq),
        .data_i   ({cmd_msg_type_i, cmd_addr_i}),
        .deq_i    (deq),
        .data_o   (head),
        .full_o   (full),
        .empty_o  (empty)
    );

    // FSM, watchdog, first-beat tracking and registered outputs
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            state         <= e_idle;
            outstanding_o <= '0;
            error_o       <= 1'b0;
            error_code_o  <= e_none;
            timer         <= '0;
            cmd_first     <= 1'b1;
            resp_first    <= 1'b1;
        end else begin
            if (cmd_fire) cmd_first <= cmd_last_i;
            if (resp_fire) resp_first <= resp_last_i;
            if (err != e_none) begin
                state        <= e_error;
                error_o      <= 1'b1;
                error_code_o <= err;
            end else if (state != e_error) begin
                state         <= (cnt_n == '0) ? e_idle : e_busy;
                outstanding_o <= cnt_n;
                timer         <= (state != e_busy || cnt_n == '0 || deq) ? '0
                               : (timer == '1) ? timer : timer + 1'b1;
            end
        end

endmodule
